// File: rtl/jstk_spi_byte_engine_if.sv
// Bus bundle between the joystick transaction controller, the SPI byte engine and the
// PmodJSTK pins.
//   start    controller -> engine  1-cycle transfer request
//   tx_byte  controller -> engine  byte to shift out
//   busy     engine -> controller  transfer in progress
//   done     engine -> controller  1-cycle completion pulse
//   rx_byte  engine -> controller  last received byte
//   sclk     engine -> pins        SPI clock, idles low
//   mosi     engine -> pins        SPI data out
//   miso     pins -> engine        SPI data in
// Modports:
//   master  the surroundings of the engine (controller plus the SPI slave)
//   slave   the byte engine itself
interface jstk_spi_byte_engine_if;
  logic       start;
  logic [7:0] tx_byte;
  logic       busy;
  logic       done;
  logic [7:0] rx_byte;
  logic       sclk;
  logic       mosi;
  logic       miso;

  modport master (
    output start,
    output tx_byte,
    output miso,
    input  busy,
    input  done,
    input  rx_byte,
    input  sclk,
    input  mosi
  );

  modport slave (
    input  start,
    input  tx_byte,
    input  miso,
    output busy,
    output done,
    output rx_byte,
    output sclk,
    output mosi
  );
endinterface

// File: rtl/jstk_spi_byte_engine.sv
// Byte-level SPI mode-0 master (CPOL=0, CPHA=0, MSB first) for the PmodJSTK link.
// The controller hands over one byte with start/tx_byte; the engine produces 8 SCLK
// pulses, shifts tx_byte out on MOSI, samples MISO on each SCLK rise and returns the
// received byte on rx_byte together with a 1-cycle done pulse. Slave select is not
// handled here.
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous active-low reset
//   bus   jstk_spi_byte_engine_if.slave (start, tx_byte, busy, done, rx_byte, sclk,
//         mosi, miso)
// Parameters:
//   HALF_PERIOD  clk cycles per SCLK half-period (>= 4)
//   CNT_W        half-period counter width, must hold HALF_PERIOD-1
// Build option:
//   JSTK_MISO_SYNC_EN  when defined, MISO passes a 2-flop synchroniser before sampling.
module jstk_spi_byte_engine #(
  parameter int unsigned HALF_PERIOD = 75,
  parameter int unsigned CNT_W       = 8
) (
  input logic                   clk,
  input logic                   rst,
  jstk_spi_byte_engine_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StSetup, StHigh, StLow, StFinish} state_e;

  localparam logic [CNT_W-1:0] HalfLast = CNT_W'(HALF_PERIOD - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] half_cnt_q, half_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       tx_shift_q, tx_shift_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic [7:0]       rx_byte_q, rx_byte_d;
  logic             sclk_q, sclk_d;
  logic             mosi_q, mosi_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             miso_s;
  logic             half_done;

`ifdef JSTK_MISO_SYNC_EN
  logic miso_meta_q, miso_sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      miso_meta_q <= 1'b0;
      miso_sync_q <= 1'b0;
    end else begin
      miso_meta_q <= bus.miso;
      miso_sync_q <= miso_meta_q;
    end
  end

  assign miso_s = miso_sync_q;
`else
  assign miso_s = bus.miso;
`endif

  assign half_done = (half_cnt_q == HalfLast);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      half_cnt_q <= '0;
      bit_cnt_q  <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_byte_q  <= '0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      half_cnt_q <= half_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      rx_byte_q  <= rx_byte_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    half_cnt_d = half_cnt_q + CNT_W'(1);
    bit_cnt_d  = bit_cnt_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_byte_d  = rx_byte_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      StIdle: begin
        half_cnt_d = '0;
        sclk_d     = 1'b0;
        if (bus.start) begin
          tx_shift_d = bus.tx_byte;
          mosi_d     = bus.tx_byte[7];
          bit_cnt_d  = '0;
          busy_d     = 1'b1;
          state_d    = StSetup;
        end
      end

      // SETUP and LOW both end in a rising SCLK edge, which is also the sample point.
      StSetup, StLow: begin
        if (half_done) begin
          half_cnt_d = '0;
          sclk_d     = 1'b1;
          rx_shift_d = {rx_shift_q[6:0], miso_s};
          state_d    = StHigh;
        end
      end

      StHigh: begin
        if (half_done) begin
          half_cnt_d = '0;
          sclk_d     = 1'b0;
          bit_cnt_d  = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = StFinish;
          end else begin
            // Next bit goes out on the falling edge, a full half-period before the rise.
            mosi_d     = tx_shift_q[6];
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
            state_d    = StLow;
          end
        end
      end

      StFinish: begin
        half_cnt_d = '0;
        rx_byte_d  = rx_shift_q;
        done_d     = 1'b1;
        busy_d     = 1'b0;
        mosi_d     = 1'b0;
        state_d    = StIdle;
      end

      default: begin
        half_cnt_d = '0;
        state_d    = StIdle;
      end
    endcase
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rx_byte = rx_byte_q;
  assign bus.sclk    = sclk_q;
  assign bus.mosi    = mosi_q;

endmodule

// File: tb/tb_jstk_spi_byte_engine.sv
// Self-checking bench for jstk_spi_byte_engine (HALF_PERIOD=4). A per-cycle step task
// plays the SPI slave and records what the SCLK/MOSI pins did; each test task compares
// that against values derived from the byte-level rules (MSB-first bits, fixed latency,
// equal half-periods).
module tb_jstk_spi_byte_engine;
  localparam int unsigned HP    = 4;
  localparam int          LAT   = 16 * HP + 1;
  localparam int          BOUND = 16 * HP + 20;

  logic clk;
  logic rst;

  jstk_spi_byte_engine_if bus ();

  jstk_spi_byte_engine #(
    .HALF_PERIOD(HP),
    .CNT_W      (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Pin-level observation state, updated once per cycle by step().
  int         j;          // negedges since start was driven
  int         rises;
  int         width_err;  // SCLK runs whose length differed from HP
  int         run_len;
  int         dones;
  int         fall_idx;
  int         mode;       // 0 byte slave, 1 loopback, 2 late-change slave, 3 passive
  logic       sclk_prev;
  logic [7:0] mosi_bits;
  logic [7:0] slave_byte;
  logic [7:0] old_byte;
  logic [7:0] new_byte;

  task automatic step();
    logic s;
    @(negedge clk);
    j++;
    s = bus.sclk;
    if (s != sclk_prev) begin
      if (run_len != int'(HP)) width_err++;
      run_len = 1;
      if (s) begin
        rises++;
        mosi_bits = {mosi_bits[6:0], bus.mosi};
      end else if (mode == 0 && fall_idx < 7) begin
        bus.miso = slave_byte[6-fall_idx];
        fall_idx++;
      end
    end else begin
      run_len++;
    end
    if (bus.done) dones++;
    if (mode == 1) bus.miso = bus.mosi;
    if (mode == 2) begin
      // Rise k happens on edge HP*(2k+1) after acceptance: present the old bit right
      // after the previous fall, switch to the new bit one clock before the rise.
      for (int k = 0; k < 8; k++) begin
        if (j == int'(HP) * (2 * k) + 1) bus.miso = old_byte[7-k];
        if (j == int'(HP) * (2 * k + 1)) bus.miso = new_byte[7-k];
      end
    end
    sclk_prev = s;
  endtask

  task automatic begin_xfer(input logic [7:0] tx);
    bus.tx_byte = tx;
    bus.start   = 1'b1;
    j           = 0;
    rises       = 0;
    width_err   = 0;
    run_len     = 0;
    mosi_bits   = 8'h00;
    fall_idx    = 0;
    dones       = 0;
  endtask

  task automatic wait_done(output int lat);
    while (!bus.done && j < BOUND) step();
    lat = bus.done ? j - 1 : -1;
  endtask

  task automatic do_xfer(input logic [7:0] tx, input logic [7:0] slv, input int md,
                         output int lat);
    mode       = md;
    slave_byte = slv;
    if (md == 0) bus.miso = slv[7];
    begin_xfer(tx);
    step();
    bus.start = 1'b0;
    wait_done(lat);
  endtask

  task automatic test_reset();
    rst  = 1'b0;
    mode = 3;
    for (int i = 0; i < 6; i++) begin
      bus.start   = logic'(i % 2);
      bus.miso    = logic'((i + 1) % 2);
      bus.tx_byte = 8'($urandom);
      @(negedge clk);
      checks++;
      if ({bus.busy, bus.done, bus.sclk, bus.mosi, bus.rx_byte} !== 12'h000) begin
        errors++;
        $display("FAIL reset_hold: busy/done/sclk/mosi/rx=%b%b%b%b/%h want 0000/00",
                 bus.busy, bus.done, bus.sclk, bus.mosi, bus.rx_byte);
      end
    end
    bus.start = 1'b0;
    rst       = 1'b1;
    step();
    checks++;
    if ({bus.busy, bus.done, bus.sclk, bus.rx_byte} !== 11'h000) begin
      errors++;
      $display("FAIL reset_release: busy/done/sclk/rx=%b%b%b/%h want 000/00",
               bus.busy, bus.done, bus.sclk, bus.rx_byte);
    end
  endtask

  task automatic test_basic();
    int lat;
    do_xfer(8'hA5, 8'h3C, 0, lat);
    checks++;
    if (lat !== LAT) begin
      errors++;
      $display("FAIL basic_latency: got %0d want %0d", lat, LAT);
    end
    checks++;
    if (mosi_bits !== 8'hA5) begin
      errors++;
      $display("FAIL basic_mosi: got %h want a5", mosi_bits);
    end
    checks++;
    if (bus.rx_byte !== 8'h3C) begin
      errors++;
      $display("FAIL basic_rx: got %h want 3c", bus.rx_byte);
    end
    checks++;
    if (rises !== 8) begin
      errors++;
      $display("FAIL basic_rises: got %0d want 8", rises);
    end
    checks++;
    if (width_err !== 0) begin
      errors++;
      $display("FAIL basic_width: got %0d bad runs want 0", width_err);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy_at_done: got %b want 0", bus.busy);
    end
    step();
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_pulse: got %b want 0", bus.done);
    end
  endtask

  task automatic test_ignore_start();
    int         lat;
    logic [7:0] slv;
    slv        = 8'($urandom);
    mode       = 0;
    slave_byte = slv;
    bus.miso   = slv[7];
    begin_xfer(8'hA5);
    step();
    bus.start = 1'b0;
    while (rises < 3 && j < BOUND) step();
    checks++;
    if (rises !== 3) begin
      errors++;
      $display("FAIL ignore_reach_rise3: got %0d want 3", rises);
    end
    bus.tx_byte = 8'hFF;
    bus.start   = 1'b1;
    step();
    bus.start = 1'b0;
    wait_done(lat);
    checks++;
    if (lat !== LAT) begin
      errors++;
      $display("FAIL ignore_latency: got %0d want %0d", lat, LAT);
    end
    checks++;
    if (mosi_bits !== 8'hA5) begin
      errors++;
      $display("FAIL ignore_mosi: got %h want a5", mosi_bits);
    end
    checks++;
    if (bus.rx_byte !== slv) begin
      errors++;
      $display("FAIL ignore_rx: got %h want %h", bus.rx_byte, slv);
    end
    for (int i = 0; i < 3 * int'(HP); i++) step();
    checks++;
    if (dones !== 1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL ignore_single_done: dones=%0d busy=%b want 1 0", dones, bus.busy);
    end
  endtask

  task automatic test_back_to_back();
    int   lat;
    logic seen_mid;
    do_xfer(8'hA5, 8'h3C, 0, lat);
    checks++;
    if (lat !== LAT) begin
      errors++;
      $display("FAIL b2b_first_latency: got %0d want %0d", lat, LAT);
    end
    mode = 1;
    begin_xfer(8'h5A);
    step();
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: busy got %b want 1", bus.busy);
    end
    seen_mid = 1'b0;
    while (!bus.done && j < BOUND) begin
      if (rises == 4 && !seen_mid) begin
        seen_mid = 1'b1;
        checks++;
        if (bus.rx_byte !== 8'h3C) begin
          errors++;
          $display("FAIL b2b_rx_hold: got %h want 3c", bus.rx_byte);
        end
      end
      step();
    end
    lat = bus.done ? j - 1 : -1;
    checks++;
    if (lat !== LAT) begin
      errors++;
      $display("FAIL b2b_second_latency: got %0d want %0d", lat, LAT);
    end
    checks++;
    if (bus.rx_byte !== 8'h5A) begin
      errors++;
      $display("FAIL b2b_rx: got %h want 5a", bus.rx_byte);
    end
    checks++;
    if (mosi_bits !== 8'h5A) begin
      errors++;
      $display("FAIL b2b_mosi: got %h want 5a", mosi_bits);
    end
    step();
  endtask

  task automatic test_abort();
    int lat;
    mode       = 0;
    slave_byte = 8'($urandom);
    bus.miso   = slave_byte[7];
    begin_xfer(8'($urandom));
    step();
    bus.start = 1'b0;
    while (rises < 3 && j < BOUND) step();
    checks++;
    if (rises !== 3) begin
      errors++;
      $display("FAIL abort_reach_rise3: got %0d want 3", rises);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.sclk, bus.mosi, bus.rx_byte} !== 11'h000) begin
      errors++;
      $display("FAIL abort_async: busy/sclk/mosi/rx=%b%b%b/%h want 000/00",
               bus.busy, bus.sclk, bus.mosi, bus.rx_byte);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (bus.sclk !== 1'b0) begin
        errors++;
        $display("FAIL abort_sclk_low: got %b want 0", bus.sclk);
      end
    end
    rst   = 1'b1;
    dones = 0;
    for (int i = 0; i < BOUND; i++) step();
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d dones want 0", dones);
    end
    do_xfer(8'h0F, 8'h00, 1, lat);
    checks++;
    if (lat !== LAT) begin
      errors++;
      $display("FAIL abort_next_latency: got %0d want %0d", lat, LAT);
    end
    checks++;
    if (bus.rx_byte !== 8'h0F) begin
      errors++;
      $display("FAIL abort_next_rx: got %h want 0f", bus.rx_byte);
    end
    step();
  endtask

  task automatic test_miso_timing();
    int         lat;
    logic [7:0] want;
    new_byte = 8'($urandom);
    old_byte = ~new_byte;
`ifdef JSTK_MISO_SYNC_EN
    want = old_byte;
`else
    want = new_byte;
`endif
    mode = 2;
    begin_xfer(8'($urandom));
    step();
    bus.start = 1'b0;
    wait_done(lat);
    checks++;
    if (lat !== LAT) begin
      errors++;
      $display("FAIL sync_latency: got %0d want %0d", lat, LAT);
    end
    checks++;
    if (bus.rx_byte !== want) begin
      errors++;
      $display("FAIL sync_rx: got %h want %h", bus.rx_byte, want);
    end
    step();
  endtask

  task automatic test_random();
    int         lat;
    logic [7:0] tx;
    logic [7:0] slv;
    int         gap;
    for (int n = 0; n < 6; n++) begin
      tx  = 8'($urandom);
      slv = 8'($urandom);
      gap = int'($urandom_range(0, 3));
      mode = 3;
      for (int g = 0; g < gap; g++) step();
      do_xfer(tx, slv, 0, lat);
      checks++;
      if (lat !== LAT || mosi_bits !== tx || bus.rx_byte !== slv || width_err !== 0) begin
        errors++;
        $display("FAIL random_xfer%0d: lat=%0d mosi=%h rx=%h wbad=%0d want %0d %h %h 0",
                 n, lat, mosi_bits, bus.rx_byte, width_err, LAT, tx, slv);
      end
      step();
    end
  endtask

  initial begin
    rst         = 1'b0;
    bus.start   = 1'b0;
    bus.tx_byte = 8'h00;
    bus.miso    = 1'b0;
    mode        = 3;
    sclk_prev   = 1'b0;
    j           = 0;
    rises       = 0;
    width_err   = 0;
    run_len     = 0;
    dones       = 0;
    fall_idx    = 0;
    mosi_bits   = 8'h00;
    slave_byte  = 8'h00;
    old_byte    = 8'h00;
    new_byte    = 8'h00;
    test_reset();
    test_basic();
    test_ignore_start();
    test_back_to_back();
    test_abort();
    test_miso_timing();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
